uart_rx_sched: RTL and testbench

- Sequencing controller for the UART receive datapath.
- Arms the receiver, captures each completed frame, masks it to the configured width and tags it with its parity-error status.
- Buffers frames in a small FIFO and presents them to a consumer over a valid/ready handshake.
- Raises an interrupt on a level threshold and keeps sticky overflow and error flags. Sits between the UART receiver and the bus-facing register block.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sched_if.sv | 36 +++
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_rx_sched.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_sched.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the UART receive sequencing controller.
//   rx_sched_state_t : controller FSM state, 3-bit encoding
//   DATA_W           : width of a received frame
//   data_mask(num)   : keep-mask for a frame of (num+1) bits, LSB-aligned
package uart_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        ARM   = 3'd1,
        RECV  = 3'd2,
        STORE = 3'd3,
        HOLD  = 3'd4
    } rx_sched_state_t;

    // Built in 17 bits so that num=15 yields an all-ones 16-bit mask.
    function automatic logic [DATA_W-1:0] data_mask(input logic [3:0] num);
        logic [DATA_W:0] m;
        m = (17'd1 << ({1'b0, num} + 5'd1)) - 17'd1;
        return m[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/uart_rx_sched_if.sv
// uart_rx_sched_if
// Bundles the receiver-side and consumer-side handshakes of the controller.
//   rx_en    : controller -> receiver, arm for the next frame
//   rx_busy  : receiver -> controller, frame in progress
//   rx_done  : receiver -> controller, one-cycle frame-complete pulse
//   rx_data  : receiver -> controller, frame, LSB-aligned
//   rx_err   : receiver -> controller, parity error for this frame
//   rd_valid : controller -> consumer, FIFO head valid
//   rd_ready : consumer -> controller, head accepted
//   rd_data  : controller -> consumer, masked head frame
//   rd_err   : controller -> consumer, head parity-error tag
// Modport master is the controller side, slave is the environment side.
interface uart_rx_sched_if;
    import uart_pkg::*;

    logic              rx_en;
    logic              rx_busy;
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_err;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    modport master (
        output rx_en, rd_valid, rd_data, rd_err,
        input  rx_busy, rx_done, rx_data, rx_err, rd_ready
    );

    modport slave (
        input  rx_en, rd_valid, rd_data, rd_err,
        output rx_busy, rx_done, rx_data, rx_err, rd_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock FIFO with registered occupancy and a synchronous flush.
//   clk, rstn : clock, asynchronous active-low reset
//   flush_i   : empties the FIFO on the next edge (wins over push/pop)
//   push_i    : write din_i; accepted when not full or when popping
//   din_i     : entry to write
//   pop_i     : remove head; ignored when empty
//   dout_o    : current head entry (register contents)
//   full_o    : level == DEPTH
//   empty_o   : level == 0
//   level_o   : registered occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter int  W     = 17,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic          doPush;
    logic          doPop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rptr_q];

    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (doPop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q <= level_q + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
        end
    end

endmodule

// File: rtl/uart_rx_sched.sv
// uart_rx_sched
// Sequencing controller for the UART receive datapath: arms the receiver,
// captures and masks each completed frame, tags it with its parity status,
// buffers it in a FIFO and presents it over a valid/ready handshake.
//   clk, rstn      : clock, asynchronous active-low reset
//   cfg_en         : enable; 0 forces OFF and flushes the FIFO
//   cfg_data_num   : frame width minus one
//   cfg_block_full : 1 = hold the receiver while full, 0 = drop newest on full
//   cfg_thresh     : irq level threshold (0 behaves as 1)
//   cfg_timeout    : idle cycles before timeout irq (optional feature)
//   clr_flags      : pulse, clears sticky flags (a coincident set wins)
//   bus            : receiver and consumer handshakes (master modport)
//   level          : FIFO occupancy
//   ovf_flag       : sticky, a frame was dropped
//   err_flag       : sticky, an errored frame was stored
//   irq            : registered level/overflow/timeout interrupt
//   state_o        : FSM state for debug
// Optional feature macro: UART_RX_TIMEOUT_EN (idle timeout counter and flag).
module uart_rx_sched
    import uart_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  TO_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_en,
    input  logic [3:0]           cfg_data_num,
    input  logic                 cfg_block_full,
    input  logic [AW:0]          cfg_thresh,
    input  logic [TO_W-1:0]      cfg_timeout,
    input  logic                 clr_flags,
    uart_rx_sched_if.master      bus,
    output logic [AW:0]          level,
    output logic                 ovf_flag,
    output logic                 err_flag,
    output logic                 irq,
    output logic [2:0]           state_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    rx_sched_state_t   state_q, state_d;
    logic [DATA_W-1:0] capData_q;
    logic              capErr_q;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;

    logic              flush;
    logic              push;
    logic              pop;
    logic              pushOk;
    logic [AW:0]       levelAfter;
    logic [AW:0]       thrEff;
    logic              toTerm;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [AW:0]       fifoLevel;
    logic [DATA_W:0]   fifoDout;

    assign flush  = ~cfg_en;
    assign push   = (state_q == STORE) & cfg_en;
    assign pop    = bus.rd_valid & bus.rd_ready;
    assign pushOk = push & (~fifoFull | pop);

    // Occupancy after this edge, so STORE can decide on HOLD using the "now full" level.
    assign levelAfter = fifoLevel + {{AW{1'b0}}, pushOk} - {{AW{1'b0}}, pop};

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (flush),
        .push_i  (push),
        .din_i   ({capErr_q, capData_q}),
        .pop_i   (pop),
        .dout_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_en) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF:     state_d = ARM;
                ARM:     if (bus.rx_busy) state_d = RECV;
                RECV:    if (bus.rx_done) state_d = STORE;
                STORE:   state_d = (cfg_block_full && (levelAfter == FULL_LVL)) ? HOLD : ARM;
                HOLD:    if (fifoLevel < FULL_LVL) state_d = ARM;
                default: state_d = OFF;
            endcase
        end
    end

    always_comb begin
        bus.rx_en = (state_q == ARM) || (state_q == RECV);
        state_o   = state_q;
    end

    // rx_done is only meaningful while RECV; elsewhere it is ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            capData_q <= '0;
            capErr_q  <= 1'b0;
        end else if ((state_q == RECV) && bus.rx_done && cfg_en) begin
            capData_q <= bus.rx_data & data_mask(cfg_data_num);
            capErr_q  <= bus.rx_err;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [TO_W-1:0] idle_q, idle_d;
    logic            to_q, to_d;

    // Idle counter restarts on any FIFO traffic and saturates at all-ones.
    always_comb begin
        idle_d = idle_q;
        if (flush || pushOk || pop || (fifoLevel == '0)) begin
            idle_d = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + TO_W'(1);
        end
        to_d = ((cfg_timeout != '0) && (idle_q == cfg_timeout)) | (to_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            to_q   <= to_d;
        end
    end

    assign toTerm = to_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = ^cfg_timeout;
    assign toTerm        = 1'b0;
`endif

    // A dropped frame only sets overflow; set beats a coincident clear.
    always_comb begin
        thrEff = (cfg_thresh == '0) ? (AW+1)'(1) : cfg_thresh;
        ovf_d  = (push & ~pushOk) | (ovf_q & ~clr_flags);
        err_d  = (pushOk & capErr_q) | (err_q & ~clr_flags);
        irq_d  = (fifoLevel >= thrEff) | ovf_q | toTerm;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    assign bus.rd_valid = ~fifoEmpty;
    assign bus.rd_data  = fifoDout[DATA_W-1:0];
    assign bus.rd_err   = fifoDout[DATA_W];
    assign level        = fifoLevel;
    assign ovf_flag     = ovf_q;
    assign err_flag     = err_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_uart_rx_sched.sv
// tb_uart_rx_sched
// Directed-sequence bench with randomized frame contents for uart_rx_sched.
// A queue-based reference model holds the expected FIFO contents and flags.
module tb_uart_rx_sched;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } frame_t;

    logic        clk;
    logic        rstn;
    logic        cfg_en;
    logic [3:0]  cfg_data_num;
    logic        cfg_block_full;
    logic [3:0]  cfg_thresh;
    logic [15:0] cfg_timeout;
    logic        clr_flags;
    logic [3:0]  level;
    logic        ovf_flag;
    logic        err_flag;
    logic        irq;
    logic [2:0]  state_o;

    uart_rx_sched_if bus ();

    uart_rx_sched #(.DEPTH(DEPTH), .TO_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_en         (cfg_en),
        .cfg_data_num   (cfg_data_num),
        .cfg_block_full (cfg_block_full),
        .cfg_thresh     (cfg_thresh),
        .cfg_timeout    (cfg_timeout),
        .clr_flags      (clr_flags),
        .bus            (bus),
        .level          (level),
        .ovf_flag       (ovf_flag),
        .err_flag       (err_flag),
        .irq            (irq),
        .state_o        (state_o)
    );

    int     vectors = 0;
    int     miscompares = 0;
    frame_t modelQ[$];
    bit     modelOvf = 0;
    bit     modelErr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=still-running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] maskOf(input logic [15:0] d, input int num);
        int v;
        v = int'(d) % (1 << (num + 1));
        return 16'(v);
    endfunction

    function automatic int thrOf(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Compares every observable against the model; call once outputs have settled.
    task automatic checkModel(input string tag);
        checkOutput({tag, ".level"}, level, modelQ.size());
        checkOutput({tag, ".rd_valid"}, bus.rd_valid, modelQ.size() > 0);
        if (modelQ.size() > 0) begin
            checkOutput({tag, ".rd_data"}, bus.rd_data, modelQ[0].d);
            checkOutput({tag, ".rd_err"}, bus.rd_err, modelQ[0].e);
        end
        checkOutput({tag, ".ovf_flag"}, ovf_flag, modelOvf);
        checkOutput({tag, ".err_flag"}, err_flag, modelErr);
        checkOutput({tag, ".irq"}, irq,
                    (modelQ.size() >= thrOf(int'(cfg_thresh))) || modelOvf);
    endtask

    // Delivers one frame through the receiver handshake and updates the model.
    task automatic applyStimulus(input logic [15:0] d, input logic e, input bit popAtStore);
        int     n;
        bit     wasEmpty;
        frame_t f;
        n = 0;
        while (bus.rx_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rx_en_armed", bus.rx_en, 1'b1);
        bus.rx_busy = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.rx_data = d;
        bus.rx_err  = e;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_busy = 1'b0;
        bus.rx_data = $urandom;
        bus.rx_err  = 1'b0;
        wasEmpty = (modelQ.size() == 0);
        if (wasEmpty) checkOutput("latency_store", bus.rd_valid, 1'b0);
        if (popAtStore && modelQ.size() > 0) begin
            checkOutput("pop_at_store.rd_data", bus.rd_data, modelQ[0].d);
            bus.rd_ready = 1'b1;
            void'(modelQ.pop_front());
        end
        @(negedge clk);
        bus.rd_ready = 1'b0;
        f.d = maskOf(d, int'(cfg_data_num));
        f.e = e;
        if (modelQ.size() < DEPTH) begin
            modelQ.push_back(f);
            if (e) modelErr = 1;
        end else begin
            modelOvf = 1;
        end
        if (wasEmpty) checkOutput("latency_valid", bus.rd_valid, 1'b1);
        waitCycles(2);
    endtask

    task automatic popOne(input string tag);
        checkOutput({tag, ".valid"}, bus.rd_valid, 1'b1);
        if (modelQ.size() > 0) begin
            checkOutput({tag, ".data"}, bus.rd_data, modelQ[0].d);
            checkOutput({tag, ".err"}, bus.rd_err, modelQ[0].e);
            void'(modelQ.pop_front());
        end
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
    endtask

    task automatic pulseClear();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        modelOvf = 0;
        modelErr = 0;
        waitCycles(2);
    endtask

    initial begin
        rstn           = 1'b0;
        cfg_en         = 1'b0;
        cfg_data_num   = 4'd7;
        cfg_block_full = 1'b0;
        cfg_thresh     = 4'd8;
        cfg_timeout    = 16'd0;
        clr_flags      = 1'b0;
        bus.rx_busy    = 1'b0;
        bus.rx_done    = 1'b0;
        bus.rx_data    = 16'h0;
        bus.rx_err     = 1'b0;
        bus.rd_ready   = 1'b0;
        waitCycles(3);
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset.state", state_o, 3'd0);
        checkOutput("reset.rx_en", bus.rx_en, 1'b0);
        checkOutput("reset.rd_data", bus.rd_data, 16'h0);
        checkOutput("reset.rd_err", bus.rd_err, 1'b0);
        checkModel("reset");

        $display("[TB] single 8-bit frame");
        cfg_en = 1'b1;
        applyStimulus(16'hA5C3, 1'b0, 0);
        checkOutput("frame8.rd_data", bus.rd_data, 16'h00C3);
        checkModel("frame8");
        popOne("frame8.pop");
        waitCycles(2);

        $display("[TB] 5-bit errored frame and flag clear");
        cfg_data_num = 4'd4;
        applyStimulus(16'hFFFF, 1'b1, 0);
        checkOutput("frame5.rd_data", bus.rd_data, 16'h001F);
        checkOutput("frame5.err_flag", err_flag, 1'b1);
        checkModel("frame5");
        pulseClear();
        checkOutput("clear.err_flag", err_flag, 1'b0);
        popOne("frame5.pop");
        waitCycles(2);
        checkModel("frame5.after");

        $display("[TB] overflow with drop-newest");
        cfg_data_num = 4'($urandom_range(15, 0));
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(16'($urandom), 1'($urandom), 0);
        end
        checkOutput("ovf.level", level, DEPTH);
        checkOutput("ovf.flag", ovf_flag, 1'b1);
        checkOutput("ovf.irq", irq, 1'b1);
        checkModel("ovf");
        pulseClear();
        checkModel("ovf.cleared");
        cfg_data_num = 4'd15;
        applyStimulus(16'($urandom), 1'b0, 1);
        checkOutput("pushpop_full.ovf", ovf_flag, 1'b0);
        checkModel("pushpop_full");
        for (int i = 0; i < DEPTH; i++) popOne("drain");
        waitCycles(2);
        checkModel("drained");

        $display("[TB] block-full hold");
        cfg_block_full = 1'b1;
        cfg_data_num   = 4'($urandom_range(15, 0));
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(16'($urandom), 1'b0, 0);
        end
        checkOutput("hold.state", state_o, 3'd4);
        checkOutput("hold.rx_en", bus.rx_en, 1'b0);
        checkModel("hold");
        popOne("hold.pop");
        waitCycles(2);
        checkOutput("rearm.state", state_o, 3'd1);
        checkOutput("rearm.rx_en", bus.rx_en, 1'b1);
        checkModel("rearm");
        for (int i = 0; i < DEPTH - 1; i++) popOne("hold.drain");
        waitCycles(2);
        checkModel("hold.drained");

        $display("[TB] threshold irq and disable mid-frame");
        cfg_block_full = 1'b0;
        cfg_thresh     = 4'd3;
        cfg_data_num   = 4'($urandom_range(15, 0));
        applyStimulus(16'($urandom), 1'b0, 0);
        applyStimulus(16'($urandom), 1'b0, 0);
        checkOutput("thresh2.irq", irq, 1'b0);
        checkModel("thresh2");
        applyStimulus(16'($urandom), 1'b0, 0);
        checkOutput("thresh3.irq", irq, 1'b1);
        checkModel("thresh3");
        bus.rx_busy = 1'b1;
        @(negedge clk);
        checkOutput("midframe.state", state_o, 3'd2);
        cfg_en = 1'b0;
        @(negedge clk);
        bus.rx_busy = 1'b0;
        modelQ.delete();
        checkOutput("disable.state", state_o, 3'd0);
        checkOutput("disable.level", level, 4'd0);
        checkOutput("disable.rd_valid", bus.rd_valid, 1'b0);
        bus.rx_done = 1'b1;
        bus.rx_data = 16'($urandom);
        @(negedge clk);
        bus.rx_done = 1'b0;
        waitCycles(3);
        checkModel("off.ignore_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
